axi_read_arbiter: RTL and testbench

//  Two-master AXI read-address arbiter: shares one downstream AR channel (toward decoder/slaves incl. default slave) between M0 (IM) and M1 (DM).

---
 rtl/axi_read_arbiter.sv | 138 +++++++++++++
 tb/tb_axi_read_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read-address arbiter with round-robin grant.
// Grant is held from AR issue until the last R beat of the burst.
module axi_read_arbiter #(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [ID_BITS-1:0]   ARID_M0,
  input  logic [ADDR_BITS-1:0] ARADDR_M0,
  input  logic [LEN_BITS-1:0]  ARLEN_M0,
  input  logic [SIZE_BITS-1:0] ARSIZE_M0,
  input  logic [1:0]           ARBURST_M0,
  input  logic                 ARVALID_M0,
  output logic                 ARREADY_M0,
  input  logic [ID_BITS-1:0]   ARID_M1,
  input  logic [ADDR_BITS-1:0] ARADDR_M1,
  input  logic [LEN_BITS-1:0]  ARLEN_M1,
  input  logic [SIZE_BITS-1:0] ARSIZE_M1,
  input  logic [1:0]           ARBURST_M1,
  input  logic                 ARVALID_M1,
  output logic                 ARREADY_M1,
  output logic [ID_BITS+3:0]   ARID_S,
  output logic [ADDR_BITS-1:0] ARADDR_S,
  output logic [LEN_BITS-1:0]  ARLEN_S,
  output logic [SIZE_BITS-1:0] ARSIZE_S,
  output logic [1:0]           ARBURST_S,
  output logic                 ARVALID_S,
  input  logic                 ARREADY_S,
  input  logic                 RVALID_S,
  input  logic                 RREADY_S,
  input  logic                 RLAST_S,
  output logic [1:0]           GRANT,
  output logic                 LEN_ERR
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t               state;
  logic                 last_m1;
  logic [LEN_BITS-1:0]  len_q;
  logic [LEN_BITS:0]    beat_cnt;
  logic                 pick_m1;
  logic                 in_addr;
  logic                 r_beat;
  logic [LEN_BITS:0]    len_ext;

  assign in_addr = (state == ADDR);
  assign r_beat  = RVALID_S & RREADY_S;
  assign len_ext = {1'b0, len_q};

  // Round-robin winner: a lone requester wins, a tie goes away from the last owner
  always_comb begin
    pick_m1 = ARVALID_M1;
    if (ARVALID_M0 && ARVALID_M1)
      pick_m1 = ~last_m1;
  end

  // Route the granted master's AR payload and handshake to the shared channel
  always_comb begin
    ARID_S     = '0;
    ARADDR_S   = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = '0;
    ARVALID_S  = 1'b0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    if (GRANT[1]) begin
      ARID_S     = {4'd1, ARID_M1};
      ARADDR_S   = ARADDR_M1;
      ARLEN_S    = ARLEN_M1;
      ARSIZE_S   = ARSIZE_M1;
      ARBURST_S  = ARBURST_M1;
      ARVALID_S  = in_addr & ARVALID_M1;
      ARREADY_M1 = in_addr & ARREADY_S;
    end else if (GRANT[0]) begin
      ARID_S     = {4'd0, ARID_M0};
      ARADDR_S   = ARADDR_M0;
      ARLEN_S    = ARLEN_M0;
      ARSIZE_S   = ARSIZE_M0;
      ARBURST_S  = ARBURST_M0;
      ARVALID_S  = in_addr & ARVALID_M0;
      ARREADY_M0 = in_addr & ARREADY_S;
    end
  end

  // Arbitration FSM: grant, issue address, then track R beats to release
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      GRANT    <= 2'b00;
      last_m1  <= 1'b1;
      len_q    <= '0;
      beat_cnt <= '0;
      LEN_ERR  <= 1'b0;
    end else begin
      LEN_ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ARVALID_M0 || ARVALID_M1) begin
            GRANT <= pick_m1 ? 2'b10 : 2'b01;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (ARVALID_S && ARREADY_S) begin
            len_q    <= GRANT[1] ? ARLEN_M1 : ARLEN_M0;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_beat) begin
            if (beat_cnt != '1)
              beat_cnt <= beat_cnt + (LEN_BITS+1)'(1);
            if (RLAST_S) begin
              state   <= IDLE;
              GRANT   <= 2'b00;
              last_m1 <= GRANT[1];
              LEN_ERR <= (beat_cnt != len_ext);
            end else if (beat_cnt == len_ext) begin
              LEN_ERR <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed corner cases, then
// randomized rounds checked by an AR scoreboard and LEN_ERR count.
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  ARID_M0, ARID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [3:0]  ARLEN_M0, ARLEN_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1;
  logic        ARVALID_M0, ARVALID_M1;
  logic        ARREADY_M0, ARREADY_M1;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S, ARREADY_S;
  logic        RVALID_S, RREADY_S, RLAST_S;
  logic [1:0]  GRANT;
  logic        LEN_ERR;

  always #5 ACLK = ~ACLK;

  axi_read_arbiter #(
    .ID_BITS(4), .ADDR_BITS(32), .LEN_BITS(4), .SIZE_BITS(3)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
    .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0),
    .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
    .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1),
    .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
    .GRANT(GRANT), .LEN_ERR(LEN_ERR)
  );

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  ar_t exp_q[$];
  bit  sb_on   = 1'b0;
  int  le_seen = 0;
  int  le_exp  = 0;
  bit  model_last_m1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Monitor: LEN_ERR pulse counter and AR scoreboard
  ar_t mon_e;
  always @(negedge ACLK) begin
    if (LEN_ERR === 1'b1) le_seen++;
    if (sb_on && !ARESET && ARVALID_S && ARREADY_S) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: unexpected AR id %0h", ARID_S);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ar_id",    ARID_S,    mon_e.id);
        chk("ar_addr",  ARADDR_S,  mon_e.addr);
        chk("ar_len",   ARLEN_S,   mon_e.len);
        chk("ar_size",  ARSIZE_S,  mon_e.size);
        chk("ar_burst", ARBURST_S, mon_e.burst);
      end
    end
    if (sb_on && !ARESET && ARVALID_S) begin
      chk("grant_vs_id", GRANT, ARID_S[4] ? 2'b10 : 2'b01);
      chk("loser_ready", GRANT[1] ? ARREADY_M0 : ARREADY_M1, 0);
    end
  end

  function automatic ar_t rand_ar(input bit m1);
    ar_t a;
    a.id    = {4'(m1), 4'($urandom_range(0, 15))};
    a.addr  = $urandom;
    a.len   = 4'($urandom_range(0, 15));
    a.size  = 3'($urandom_range(0, 7));
    a.burst = 2'($urandom_range(0, 2));
    return a;
  endfunction

  task automatic run_round(input int req);
    ar_t a0, a1;
    bit  hs0, hs1, hss, bt;
    bit  busy;
    int  left, le_chk, k, bidx;
    logic [3:0] slen;
    bit  done;
    a0 = rand_ar(1'b0);
    a1 = rand_ar(1'b1);
    left = 0;
    if (req[0] && req[1]) begin
      if (model_last_m1) begin
        exp_q.push_back(a0); exp_q.push_back(a1); model_last_m1 = 1'b1;
      end else begin
        exp_q.push_back(a1); exp_q.push_back(a0); model_last_m1 = 1'b0;
      end
      left = 2;
    end else if (req[0]) begin
      exp_q.push_back(a0); model_last_m1 = 1'b0; left = 1;
    end else begin
      exp_q.push_back(a1); model_last_m1 = 1'b1; left = 1;
    end
    ARID_M0 = a0.id[3:0]; ARADDR_M0 = a0.addr; ARLEN_M0 = a0.len;
    ARSIZE_M0 = a0.size; ARBURST_M0 = a0.burst; ARVALID_M0 = req[0];
    ARID_M1 = a1.id[3:0]; ARADDR_M1 = a1.addr; ARLEN_M1 = a1.len;
    ARSIZE_M1 = a1.size; ARBURST_M1 = a1.burst; ARVALID_M1 = req[1];
    ARREADY_S = 1'($urandom_range(0, 1));
    busy = 0; le_chk = 0; k = 0; bidx = 0; done = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge ACLK);
      if (le_chk > 0) begin
        le_chk--;
        if (le_chk == 0) chk("len_err_count", le_seen, le_exp);
      end
      if (left == 0 && le_chk == 0) begin
        done = 1;
        break;
      end
      hs0  = ARVALID_M0 && ARREADY_M0;
      hs1  = ARVALID_M1 && ARREADY_M1;
      hss  = ARVALID_S && ARREADY_S;
      slen = ARLEN_S;
      bt   = RVALID_S && RREADY_S;
      @(posedge ACLK);
      #1;
      if (hs0) ARVALID_M0 = 1'b0;
      if (hs1) ARVALID_M1 = 1'b0;
      if (hss) begin
        busy = 1; bidx = 0;
        if ($urandom_range(0, 3) != 0) k = int'(slen);
        else k = $urandom_range(0, int'(slen) + 2);
        if (k < int'(slen)) le_exp += 1;
        else if (k > int'(slen)) le_exp += 2;
      end else if (bt && busy) begin
        if (bidx == k) begin
          busy = 0; left--; le_chk = 2;
        end else begin
          bidx++;
        end
      end
      ARREADY_S = ($urandom_range(0, 3) != 0);
      RVALID_S  = busy && ($urandom_range(0, 3) != 0);
      RREADY_S  = busy && ($urandom_range(0, 3) != 0);
      RLAST_S   = busy && (bidx == k);
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL round_timeout: req %0d bursts_left %0d", req, left);
    end
    ARVALID_M0 = 0; ARVALID_M1 = 0; ARREADY_S = 0;
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1;
    ARID_M0 = 0; ARADDR_M0 = 0; ARLEN_M0 = 0; ARSIZE_M0 = 0;
    ARBURST_M0 = 0; ARVALID_M0 = 0;
    ARID_M1 = 0; ARADDR_M1 = 0; ARLEN_M1 = 0; ARSIZE_M1 = 0;
    ARBURST_M1 = 0; ARVALID_M1 = 0;
    ARREADY_S = 0; RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
    repeat (3) tick();
    @(negedge ACLK);
    chk("rst_grant",   GRANT, 0);
    chk("rst_arvalid", ARVALID_S, 0);
    chk("rst_lenerr",  LEN_ERR, 0);
    chk("rst_rdy0",    ARREADY_M0, 0);
    chk("rst_rdy1",    ARREADY_M1, 0);
    tick();
    ARESET = 0;

    // M0 alone, single beat, one-cycle AR latency
    ARID_M0 = 4'h3; ARLEN_M0 = 0; ARADDR_M0 = 32'h1000;
    ARVALID_M0 = 1; ARREADY_S = 1;
    @(negedge ACLK);
    chk("lat_idle_arvalid", ARVALID_S, 0);
    tick();
    @(negedge ACLK);
    chk("lat_arvalid", ARVALID_S, 1);
    chk("lat_arid",    ARID_S, 8'h03);
    chk("lat_grant",   GRANT, 2'b01);
    chk("lat_rdy0",    ARREADY_M0, 1);
    tick();
    ARVALID_M0 = 0; RVALID_S = 1; RREADY_S = 1; RLAST_S = 1;
    @(negedge ACLK);
    chk("data_grant",   GRANT, 2'b01);
    chk("data_arvalid", ARVALID_S, 0);
    tick();
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
    @(negedge ACLK);
    chk("b1_grant_rel", GRANT, 0);
    chk("b1_lenerr",    LEN_ERR, 0);

    // M1 with slave stalling AR for 5 cycles, then short burst
    ARREADY_S = 0; ARID_M1 = 4'h5; ARLEN_M1 = 4'd3;
    ARADDR_M1 = 32'hABCD0; ARVALID_M1 = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("stall_arvalid", ARVALID_S, 1);
      chk("stall_addr",    ARADDR_S, 32'hABCD0);
      chk("stall_id",      ARID_S, 8'h15);
      chk("stall_rdy1",    ARREADY_M1, 0);
      tick();
    end
    ARREADY_S = 1;
    @(negedge ACLK);
    chk("stall_rdy1_up", ARREADY_M1, 1);
    tick();
    ARVALID_M1 = 0; ARREADY_S = 0; RVALID_S = 1; RREADY_S = 1;
    tick();
    tick();
    RLAST_S = 1;
    tick();
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
    @(negedge ACLK);
    chk("short_lenerr", LEN_ERR, 1);
    chk("short_grant",  GRANT, 0);
    tick();
    @(negedge ACLK);
    chk("short_lenerr_off", LEN_ERR, 0);

    // M0 requests while M1 owns the data phase
    ARID_M1 = 4'h2; ARLEN_M1 = 4'd1; ARVALID_M1 = 1; ARREADY_S = 1;
    tick();
    tick();
    ARVALID_M1 = 0; ARID_M0 = 4'h7; ARVALID_M0 = 1;
    @(negedge ACLK);
    chk("busy_rdy0",  ARREADY_M0, 0);
    chk("busy_grant", GRANT, 2'b10);
    RVALID_S = 1; RREADY_S = 1;
    tick();
    RLAST_S = 1;
    tick();
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
    @(negedge ACLK);
    chk("busy_idle_grant", GRANT, 0);
    chk("busy_idle_rdy0",  ARREADY_M0, 0);
    tick();
    @(negedge ACLK);
    chk("busy_next_grant", GRANT, 2'b01);
    chk("busy_next_rdy0",  ARREADY_M0, 1);

    // Reset in the middle of the data phase
    tick();
    ARVALID_M0 = 0; RVALID_S = 1; RREADY_S = 1;
    tick();
    ARESET = 1;
    tick();
    ARESET = 0; RVALID_S = 0; RREADY_S = 0;
    @(negedge ACLK);
    chk("mrst_grant",   GRANT, 0);
    chk("mrst_arvalid", ARVALID_S, 0);
    ARVALID_M0 = 1; ARVALID_M1 = 1; ARREADY_S = 0;
    tick();
    @(negedge ACLK);
    chk("mrst_m0_first", GRANT, 2'b01);
    ARVALID_M0 = 0; ARVALID_M1 = 0; ARESET = 1;
    tick();
    tick();
    ARESET = 0;

    // Randomized rounds against the transaction-level model
    model_last_m1 = 1'b1;
    le_seen = 0;
    le_exp  = 0;
    sb_on   = 1'b1;
    for (int r = 0; r < 40; r++)
      run_round($urandom_range(1, 3));
    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    chk("len_err_total", le_seen, le_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
